pattern_writer: RTL and testbench
=================================

PATTERN_WRITER -- requirements
Module: pattern_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, pattern memory address width (4096 entries, same depth as the LED shift pattern reader).
REQ-002 SHALL have parameter DATA_W, default 4, pattern word width (one bit per LED).
REQ-003 SHALL have parameter DEB_CYCLES, default 16, number of consecutive stable clk cycles required to accept a switch level.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port sw_in, input, DATA_W, asynchronous switch levels to record.
REQ-008 SHALL have port rec_en, input, 1, asynchronous record-enable level.
REQ-009 SHALL have port tick, input, 1, one-cycle sample strobe synchronous to clk.
REQ-010 SHALL have port wr_en, output, 1, write request to pattern memory.
REQ-011 SHALL have port wr_addr, output, ADDR_W, write address.
REQ-012 SHALL have port wr_data, output, DATA_W, write data.
REQ-013 SHALL have port wr_ready, input, 1, memory accepts the write in any cycle where wr_en and wr_ready are both 1.
REQ-014 SHALL have port full, output, 1, all 2^ADDR_W entries written in the current recording.
REQ-015 SHALL have port overrun, output, 1, sticky flag: a tick was dropped.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-017 SHALL pass sw_in and rec_en through two-flop synchronizers before any use; latency 2 clk.
REQ-018 SHALL update each debounced sw bit only after its synchronized value differs from the current debounced value for DEB_CYCLES consecutive cycles; any bounce restarts that bit's counter.
REQ-019 SHALL implement the states IDLE, WAIT_TICK, WRITE, and DONE.
REQ-020 IDLE: on a synchronized rec_en rising edge, SHALL clear wr_addr, full, and overrun, then go to WAIT_TICK.
REQ-021 WAIT_TICK: on tick=1, SHALL load wr_data from the debounced switches, assert wr_en, and go to WRITE; if rec_en=0 and tick=0, SHALL go to IDLE.
REQ-022 WRITE: SHALL hold wr_en, wr_addr, and wr_data stable until wr_en&&wr_ready; in that cycle SHALL deassert wr_en on the next edge.
REQ-023 WRITE completion: if wr_addr==2^ADDR_W-1, SHALL set full and go to DONE (no address wrap); else SHALL increment wr_addr and go to WAIT_TICK, or to IDLE if rec_en=0.
REQ-024 SHALL complete an in-flight write when rec_en falls during WRITE; it SHALL never abandon a write.
REQ-025 tick=1 while in WRITE SHALL be dropped and SHALL set overrun; overrun SHALL clear only on reset or a new recording start.
REQ-026 DONE: SHALL ignore tick, keep full=1, and go to IDLE when rec_en=0; full SHALL stay 1 until the next recording start.
REQ-027 wr_en SHALL be registered and SHALL never be asserted outside WRITE.
REQ-028 Best-case throughput SHALL be one write per 2 clk (tick, then ready).

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, wr_en=0, wr_addr=0, wr_data=0, full=0, overrun=0, busy=0, clear all synchronizers and debounce counters, and set the debounced value to 0.
REQ-030 Reset during WRITE SHALL drop wr_en asynchronously; the partial write is not retried.

Structure
REQ-031 ADDR_W and DATA_W defaults and the state enumeration SHALL live in a shared package, also used by the shift pattern reader.
REQ-032 The per-bit synchronizer plus debounce logic SHALL be one sub-module, pattern_debounce, instantiated DATA_W times.

Verification
REQ-033 Basic write: sw_in=4'hA held 40 clk, rec_en=1, tick pulse, wr_ready=1 -> one write, addr 0, data 4'hA; wr_addr is 1 afterwards.
REQ-034 Bounce: sw_in toggles every 5 clk for 50 clk, then holds 4'h5, tick pulses at clk 60 -> data written is the previous stable value, not 4'h5; a tick at clk 90 writes 4'h5.
REQ-035 Backpressure: wr_ready=0 for 10 clk after wr_en, with tick pulses during that window -> wr_en, addr, and data stay stable; overrun=1; exactly one write is accepted.
REQ-036 Fill: 4096 ticks with wr_ready=1 -> addresses 0..4095 written once each; full=1, state DONE; a further tick produces no write.
REQ-037 Stop mid-write: rec_en falls while in WRITE with wr_ready=0, then wr_ready=1 -> the write completes, then IDLE with busy=0.
REQ-038 Reset mid-write: rst pulse while wr_en=1 -> wr_en=0 the same cycle; all outputs return to 0.

Source files
------------

// File: rtl/pattern_writer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pattern_writer_pkg
// Description : Shared definitions for the LED pattern path. The pattern
//               writer and the shift pattern reader both use this package, so
//               they agree on memory geometry and the recorder state encoding.
//               Contents:
//                 c_ADDR_W   - default pattern memory address width (4096 words)
//                 c_DATA_W   - default pattern word width (one bit per LED)
//                 pw_state_t - recorder states IDLE / WAIT_TICK / WRITE / DONE
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_writer_pkg;

    localparam int c_ADDR_W = 12;
    localparam int c_DATA_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TICK = 2'd1,
        ST_WRITE     = 2'd2,
        ST_DONE      = 2'd3
    } pw_state_t;

endpackage
`default_nettype wire

// File: rtl/pattern_debounce.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pattern_debounce
// Description : One switch bit. The bit goes through a two-flop synchronizer,
//               then a debouncer. The debounced level takes the synchronized
//               value only after that value has differed from it for
//               DEB_CYCLES consecutive clocks. Any return to the current
//               debounced level restarts the count.
//   clk      in  clock, rising edge
//   rst      in  asynchronous active-high reset
//   sw_async in  raw switch level
//   sw_deb   out debounced level (0 after reset)
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_async,
    output logic sw_deb
);

    localparam int c_CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_deb;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= sw_async;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                // This clock is the DEB_CYCLES-th consecutive differing cycle.
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign sw_deb = r_deb;

endmodule
`default_nettype wire

// File: rtl/pattern_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pattern_writer
// Description : Records debounced switch levels into the pattern memory.
//               While rec_en is high, each tick writes one word at the next
//               address. Recording stops at the last address and does not
//               wrap. A tick that arrives during an outstanding write is
//               dropped and sets overrun.
//   clk      in  sole clock, rising edge
//   rst      in  asynchronous active-high reset
//   sw_in    in  [DATA_W] asynchronous switch levels
//   rec_en   in  asynchronous record enable
//   tick     in  one-cycle sample strobe (clk domain)
//   wr_en    out write request (registered, high only in WRITE)
//   wr_addr  out [ADDR_W] write address
//   wr_data  out [DATA_W] write data
//   wr_ready in  memory accepts when wr_en && wr_ready
//   full     out all 2^ADDR_W words written in this recording
//   overrun  out sticky: a tick was dropped
//   busy     out state is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_writer
    import pattern_writer_pkg::*;
#(
    parameter int ADDR_W     = c_ADDR_W,
    parameter int DATA_W     = c_DATA_W,
    parameter int DEB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sw_in,
    input  logic              rec_en,
    input  logic              tick,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              full,
    output logic              overrun,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = {ADDR_W{1'b1}};

    logic [DATA_W-1:0] w_sw_deb;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
            pattern_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk      (clk),
                .rst      (rst),
                .sw_async (sw_in[gi]),
                .sw_deb   (w_sw_deb[gi])
            );
        end
    endgenerate

    pw_state_t         r_state;
    logic              r_rec_s1;
    logic              r_rec_s2;
    logic              r_rec_prev;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_full;
    logic              r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rec_s1   <= 1'b0;
            r_rec_s2   <= 1'b0;
            r_rec_prev <= 1'b0;
            r_state    <= ST_IDLE;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_full     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_rec_s1   <= rec_en;
            r_rec_s2   <= r_rec_s1;
            r_rec_prev <= r_rec_s2;

            case (r_state)
                ST_IDLE: begin
                    // Only a fresh rising edge starts a recording. A level that
                    // is still high after DONE does not restart one.
                    if (r_rec_s2 && !r_rec_prev) begin
                        r_wr_addr <= '0;
                        r_full    <= 1'b0;
                        r_overrun <= 1'b0;
                        r_state   <= ST_WAIT_TICK;
                    end
                end

                ST_WAIT_TICK: begin
                    // A tick wins over a falling rec_en in the same cycle.
                    if (tick) begin
                        r_wr_data <= w_sw_deb;
                        r_wr_en   <= 1'b1;
                        r_state   <= ST_WRITE;
                    end else if (!r_rec_s2) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_WRITE: begin
                    if (tick) begin
                        r_overrun <= 1'b1;
                    end
                    if (r_wr_en && wr_ready) begin
                        r_wr_en <= 1'b0;
                        if (r_wr_addr == c_LAST_ADDR) begin
                            r_full  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_wr_addr <= r_wr_addr + 1'b1;
                            r_state   <= r_rec_s2 ? ST_WAIT_TICK : ST_IDLE;
                        end
                    end
                end

                ST_DONE: begin
                    if (!r_rec_s2) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign full    = r_full;
    assign overrun = r_overrun;
    assign busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pattern_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pattern_writer
// Description : Self-checking bench for pattern_writer. The stimulus process
//               keeps a transaction-level model of the recorder. Each accepted
//               tick pushes the expected (address, data) pair into a queue. A
//               separate monitor pops the queue on every accepted memory write
//               and compares the pair. The monitor also checks that the write
//               request holds steady under backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_writer;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] sw_in;
    logic              rec_en;
    logic              tick;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              full;
    logic              overrun;
    logic              busy;

    pattern_writer #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DEB_CYCLES (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_in    (sw_in),
        .rec_en   (rec_en),
        .tick     (tick),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .full     (full),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_writes = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_data_q[$];

    // Transaction-level model of the recorder
    int                m_addr;
    bit                m_full;
    bit                m_overrun;
    bit                m_active;
    bit                m_pending;
    bit                m_stop;
    logic [DATA_W-1:0] m_sw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted write. Samples at negedge.
    bit                have_prev = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_data;
    logic [ADDR_W-1:0] pop_addr;
    logic [DATA_W-1:0] pop_data;

    always @(negedge clk) begin
        if (rst) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev)
                chk("hold_under_backpressure", {wr_en, wr_addr, wr_data}, {1'b1, prev_addr, prev_data});
            if (wr_en)
                chk("wr_en_implies_busy", busy, 1);
            if (wr_en && wr_ready) begin
                n_writes++;
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_write_addr", wr_addr, 32'hFFFF_FFFF);
                end else begin
                    pop_addr = exp_addr_q.pop_front();
                    pop_data = exp_data_q.pop_front();
                    chk("write_addr", wr_addr, pop_addr);
                    chk("write_data", wr_data, pop_data);
                end
            end
            have_prev = wr_en && !wr_ready;
            prev_addr = wr_addr;
            prev_data = wr_data;
        end
    end

    // One clock of stimulus. Inputs change just after the rising edge. The
    // model then decides what the next edge does with them.
    task automatic step(input bit t, input bit r);
        @(posedge clk);
        #1;
        tick     = t;
        wr_ready = r;
        if (m_active && !m_full) begin
            if (m_pending) begin
                if (t) m_overrun = 1'b1;
                if (r) begin
                    m_pending = 1'b0;
                    if (m_addr == DEPTH - 1) m_full = 1'b1;
                    else                     m_addr = m_addr + 1;
                    if (m_stop) m_active = 1'b0;
                end
            end else if (t) begin
                exp_addr_q.push_back(m_addr[ADDR_W-1:0]);
                exp_data_q.push_back(m_sw);
                m_pending = 1'b1;
            end
        end
    endtask

    task automatic settle_sw(input logic [DATA_W-1:0] v);
        sw_in = v;
        repeat (25) step(0, 0);
        m_sw = v;
    endtask

    task automatic start_rec();
        rec_en = 1'b0;
        repeat (4) step(0, 0);
        rec_en = 1'b1;
        repeat (5) step(0, 0);
        m_addr = 0; m_full = 0; m_overrun = 0;
        m_active = 1; m_pending = 0; m_stop = 0;
    endtask

    task automatic stop_rec();
        rec_en = 1'b0;
        m_stop = 1'b1;
        if (!m_pending) m_active = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_addr_q.size() != 0 || m_pending) && guard < 60) begin
            step(0, 1);
            guard++;
        end
        if (guard >= 60) chk("drain_timeout", exp_addr_q.size(), 0);
        step(0, 0);
        step(0, 0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_addr"},    wr_addr, m_addr);
        chk({tag, "_overrun"}, overrun, m_overrun);
        chk({tag, "_full"},    full,    m_full);
    endtask

    initial begin
        int w0;
        rst = 1'b1; sw_in = '0; rec_en = 1'b0; tick = 1'b0; wr_ready = 1'b0;
        m_addr = 0; m_full = 0; m_overrun = 0; m_active = 0; m_pending = 0; m_stop = 0; m_sw = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wr_en", wr_en, 0);
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_wr_data", wr_data, 0);
        chk("reset_full", full, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;

        // Basic write: 4'hA, one tick
        settle_sw(4'hA);
        start_rec();
        chk("busy_recording", busy, 1);
        step(1, 1);
        drain();
        chk("basic_addr_after", wr_addr, 1);
        check_model("basic");

        // Back-to-back: tick every 2 clocks with ready high, no drops
        w0 = n_writes;
        repeat (8) begin step(1, 1); step(0, 1); end
        drain();
        chk("throughput_writes", n_writes - w0, 8);
        check_model("throughput");

        // Backpressure with ticks during the stall
        w0 = n_writes;
        step(1, 0);
        for (int i = 0; i < 10; i++) step((i % 3) == 1, 0);
        step(0, 1);
        drain();
        chk("backpressure_writes", n_writes - w0, 1);
        chk("backpressure_overrun", overrun, 1);
        check_model("backpressure");

        // Bounce: the debounced value must keep the last stable level 4'hA
        start_rec();
        chk("restart_clears_overrun", overrun, 0);
        for (int i = 0; i < 10; i++) begin
            sw_in = (i % 2 == 0) ? 4'h5 : 4'hA;
            repeat (5) step(0, 0);
        end
        sw_in = 4'h5;
        repeat (10) step(0, 0);
        step(1, 1);
        repeat (29) step(0, 0);
        m_sw = 4'h5;
        step(1, 1);
        drain();
        check_model("bounce");

        // Randomized segments
        for (int s = 0; s < 3; s++) begin
            settle_sw(DATA_W'($urandom_range(0, 15)));
            repeat (150) step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
            drain();
            check_model("random");
        end

        // Stop mid-write: the write still completes, then IDLE
        start_rec();
        step(1, 0);
        step(0, 0);
        stop_rec();
        repeat (5) step(0, 0);
        chk("stop_wr_en_held", wr_en, 1);
        step(0, 1);
        drain();
        chk("stop_busy", busy, 0);
        chk("stop_addr", wr_addr, 1);

        // Fill all addresses
        start_rec();
        w0 = n_writes;
        for (int i = 0; i < DEPTH; i++) begin step(1, 1); step(0, 1); end
        drain();
        chk("fill_writes", n_writes - w0, DEPTH);
        chk("fill_busy_done", busy, 1);
        check_model("fill");
        w0 = n_writes;
        step(1, 1);
        repeat (4) step(0, 1);
        chk("done_ignores_tick", n_writes - w0, 0);
        chk("done_overrun", overrun, 0);
        stop_rec();
        repeat (5) step(0, 0);
        chk("done_to_idle_busy", busy, 0);
        chk("full_sticky_in_idle", full, 1);

        // Reset mid-write
        start_rec();
        step(1, 0);
        step(0, 0);
        #2;
        chk("pre_reset_wr_en", wr_en, 1);
        rst = 1'b1;
        #1;
        chk("async_reset_wr_en", wr_en, 0);
        chk("async_reset_outputs", {wr_addr, wr_data, full, overrun, busy}, 0);
        exp_addr_q.delete();
        exp_data_q.delete();
        m_active = 0; m_pending = 0; m_addr = 0; m_full = 0; m_overrun = 0;
        rec_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) step(0, 1);
        chk("post_reset_busy", busy, 0);
        chk("final_queue_empty", exp_addr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
